// File: rtl/bcd_countdown.sv
// BCD countdown timer core: adjustable value, run/pause, timed alarm window and
// a pause blink mask. Arithmetic is done digit-wise so the display needs no conversion.
module bcd_countdown #(
   parameter int DIGITS     = 4,
   parameter int TICK_DIV   = 1000000,
   parameter int MMSS       = 1,
   parameter int STEP_DIGIT = 2,
   parameter int ALARM_SECS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  plus,
   input  logic                  minus,
   input  logic                  start,
   input  logic                  clear,
   output logic [4*DIGITS-1:0]   display,
   output logic                  blank,
   output logic                  running,
   output logic                  finish,
   output logic                  alarm
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int BW = $clog2(TICK_DIV / 2);
   localparam int AW = $clog2(ALARM_SECS + 1);

   typedef logic [DIGITS-1:0][3:0] bcd_t;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

   // In MM:SS mode the tens-of-seconds digit wraps at 5, every other digit at 9.
   function automatic logic [3:0] dig_max(input int i);
      return (MMSS != 0 && i == 1) ? 4'd5 : 4'd9;
   endfunction

   function automatic bcd_t max_val();
      bcd_t r;
      for (int i = 0; i < DIGITS; i++) r[i] = dig_max(i);
      return r;
   endfunction

   function automatic bcd_t add_unit(input bcd_t v, input int k);
      bcd_t r;
      logic cy;
      r  = v;
      cy = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (i >= k && cy) begin
            if (v[i] == dig_max(i)) r[i] = 4'd0;
            else begin
               r[i] = v[i] + 4'd1;
               cy   = 1'b0;
            end
         end
      end
      return cy ? max_val() : r;
   endfunction

   // Borrow out of the top digit means the value was below one unit: floor at zero.
   function automatic bcd_t sub_unit(input bcd_t v, input int k);
      bcd_t r;
      logic bw;
      r  = v;
      bw = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (i >= k && bw) begin
            if (v[i] == 4'd0) r[i] = dig_max(i);
            else begin
               r[i] = v[i] - 4'd1;
               bw   = 1'b0;
            end
         end
      end
      return bw ? '0 : r;
   endfunction

   state_t          state, nxt_state;
   bcd_t            value, nxt_value, dec;
   logic [PW-1:0]   presc, nxt_presc;
   logic [BW-1:0]   bcnt, nxt_bcnt;
   logic [AW-1:0]   acnt, nxt_acnt;
   logic            phase, nxt_phase, tick;
   logic            o_blank, o_running, o_finish, o_alarm;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
         value <= '0;
         presc <= '0;
         bcnt  <= '0;
         acnt  <= '0;
         phase <= 1'b0;
      end else begin
         state <= nxt_state;
         value <= nxt_value;
         presc <= nxt_presc;
         bcnt  <= nxt_bcnt;
         acnt  <= nxt_acnt;
         phase <= nxt_phase;
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_value = value;
      nxt_presc = presc;
      nxt_bcnt  = bcnt;
      nxt_acnt  = acnt;
      nxt_phase = phase;
      tick      = (presc == PW'(TICK_DIV - 1));
      dec       = sub_unit(value, 0);
      case (state)
         S_IDLE: begin
            if (clear) nxt_value = '0;
            else if (start) begin
               if (value != '0) begin
                  nxt_state = S_RUN;
                  nxt_presc = '0;
               end
            end
            else if (plus)  nxt_value = add_unit(value, STEP_DIGIT);
            else if (minus) nxt_value = sub_unit(value, STEP_DIGIT);
         end
         S_RUN: begin
            if (clear) begin
               nxt_state = S_IDLE;
               nxt_value = '0;
            end else begin
               nxt_presc = tick ? '0 : presc + 1'b1;
               if (tick) nxt_value = dec;
               // A tick reaching zero beats a same-cycle pause request.
               if (tick && dec == '0) begin
                  nxt_state = S_DONE;
                  nxt_presc = '0;
                  nxt_acnt  = '0;
               end else if (start) begin
                  nxt_state = S_PAUSE;
                  nxt_bcnt  = '0;
                  nxt_phase = 1'b0;
               end
            end
         end
         S_PAUSE: begin
            if (clear) begin
               nxt_state = S_IDLE;
               nxt_value = '0;
               nxt_phase = 1'b0;
            end else if (start) begin
               nxt_state = S_RUN;
               nxt_phase = 1'b0;
            end else if (bcnt == BW'(TICK_DIV / 2 - 1)) begin
               nxt_bcnt  = '0;
               nxt_phase = ~phase;
            end else begin
               nxt_bcnt  = bcnt + 1'b1;
            end
         end
         S_DONE: begin
            if (clear || start || plus || minus) nxt_state = S_IDLE;
            else begin
               nxt_presc = tick ? '0 : presc + 1'b1;
               if (tick) begin
                  if (acnt == AW'(ALARM_SECS - 1)) nxt_state = S_IDLE;
                  else nxt_acnt = acnt + 1'b1;
               end
            end
         end
         default: nxt_state = S_IDLE;
      endcase
   end

   always_comb begin
      o_running = (nxt_state == S_RUN);
      o_alarm   = (nxt_state == S_DONE);
      o_finish  = (nxt_state == S_DONE) && (state != S_DONE);
      o_blank   = (nxt_state == S_PAUSE) && nxt_phase;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         blank   <= 1'b0;
         running <= 1'b0;
         finish  <= 1'b0;
         alarm   <= 1'b0;
      end else begin
         blank   <= o_blank;
         running <= o_running;
         finish  <= o_finish;
         alarm   <= o_alarm;
      end
   end

   assign display = value;

endmodule

// File: tb/tb_bcd_countdown.sv
// Bench for bcd_countdown: a seconds-based model checked every cycle, plus
// hand-computed literals, and a small pure-decimal instance.
module tb_bcd_countdown;

   localparam int TD   = 4;
   localparam int AS   = 3;
   localparam int UNIT = 60;
   localparam int MAXV = 99 * 60 + 59;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        plus, minus, start, clear;
   logic [15:0] display;
   logic        blank, running, finish, alarm;

   logic        d2_plus, d2_minus, d2_start, d2_clear;
   logic [11:0] d2_display;
   logic        d2_blank, d2_running, d2_finish, d2_alarm;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bcd_countdown #(.DIGITS(4), .TICK_DIV(TD), .MMSS(1), .STEP_DIGIT(2), .ALARM_SECS(AS)) dut (
      .clk(clk), .rst_n(rst_n), .plus(plus), .minus(minus), .start(start), .clear(clear),
      .display(display), .blank(blank), .running(running), .finish(finish), .alarm(alarm));

   bcd_countdown #(.DIGITS(3), .TICK_DIV(TD), .MMSS(0), .STEP_DIGIT(2), .ALARM_SECS(AS)) dut2 (
      .clk(clk), .rst_n(rst_n), .plus(d2_plus), .minus(d2_minus), .start(d2_start),
      .clear(d2_clear), .display(d2_display), .blank(d2_blank), .running(d2_running),
      .finish(d2_finish), .alarm(d2_alarm));

   // Model: value is plain seconds; state 0 idle, 1 run, 2 pause, 3 done.
   int m_st = 0, m_v = 0, m_pr = 0, m_bc = 0, m_ph = 0, m_ac = 0, m_fin = 0;

   function automatic logic [15:0] to_disp(input int v);
      int mn, sc;
      mn = v / 60;
      sc = v % 60;
      return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
   endfunction

   always @(posedge clk) begin
      automatic int st = m_st, v = m_v, pr = m_pr, bc = m_bc, ph = m_ph, ac = m_ac, fin = 0;
      automatic bit tk;
      if (!rst_n) begin
         st = 0; v = 0; pr = 0; bc = 0; ph = 0; ac = 0;
      end else begin
         case (st)
            0: begin
               if (clear) v = 0;
               else if (start) begin
                  if (v != 0) begin st = 1; pr = 0; end
               end
               else if (plus)  v = (v + UNIT > MAXV) ? MAXV : v + UNIT;
               else if (minus) v = (v < UNIT) ? 0 : v - UNIT;
            end
            1: begin
               if (clear) begin st = 0; v = 0; end
               else begin
                  tk = (pr == TD - 1);
                  pr = tk ? 0 : pr + 1;
                  if (tk) v = v - 1;
                  if (tk && v == 0) begin st = 3; pr = 0; ac = 0; fin = 1; end
                  else if (start) begin st = 2; bc = 0; ph = 0; end
               end
            end
            2: begin
               if (clear) begin st = 0; v = 0; end
               else if (start) st = 1;
               else begin
                  bc = bc + 1;
                  if (bc == TD / 2) begin bc = 0; ph = 1 - ph; end
               end
            end
            default: begin
               if (clear || start || plus || minus) st = 0;
               else begin
                  tk = (pr == TD - 1);
                  pr = tk ? 0 : pr + 1;
                  if (tk) begin
                     ac = ac + 1;
                     if (ac == AS) st = 0;
                  end
               end
            end
         endcase
      end
      m_st <= st; m_v <= v; m_pr <= pr; m_bc <= bc; m_ph <= ph; m_ac <= ac; m_fin <= fin;
   end

   always @(negedge clk) begin
      automatic logic [19:0] act, exp;
      act = {display, blank, running, finish, alarm};
      exp = {to_disp(m_v), (m_st == 2) && (m_ph != 0), m_st == 1, m_fin != 0, m_st == 3};
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL model t=%0t dut=%h want=%h", $time, act, exp);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic p, input logic m, input logic s, input logic c);
      plus = p; minus = m; start = s; clear = c;
      @(negedge clk);
      plus = 1'b0; minus = 1'b0; start = 1'b0; clear = 1'b0;
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      plus = 0; minus = 0; start = 0; clear = 0; rst_n = 0;
      d2_plus = 0; d2_minus = 0; d2_start = 0; d2_clear = 0;
      wait_n(2);
      chk("rst_display", 32'(display), 32'h0);
      chk("rst_flags", 32'({blank, running, finish, alarm}), 32'h0);
      rst_n = 1;

      repeat (3) drive(1, 0, 0, 0);
      chk("plus3", 32'(display), 32'h0300);
      drive(0, 0, 1, 0);
      chk("run", 32'(running), 32'h1);
      wait_n(4);
      chk("tick1", 32'(display), 32'h0259);
      wait_n(4);
      chk("tick2", 32'(display), 32'h0258);
      drive(0, 0, 1, 1);
      chk("clr_start_disp", 32'(display), 32'h0);
      chk("clr_start_run", 32'(running), 32'h0);

      drive(0, 0, 1, 0);
      chk("start_at_zero", 32'(running), 32'h0);
      drive(0, 1, 0, 0);
      chk("minus_floor", 32'(display), 32'h0);
      drive(1, 0, 0, 0);
      drive(1, 1, 0, 0);
      chk("plus_beats_minus", 32'(display), 32'h0200);
      drive(0, 1, 0, 0);
      chk("minus", 32'(display), 32'h0100);

      // 01:00 counted down to 00:02, then two more ticks to DONE.
      drive(0, 0, 1, 0);
      wait_n(4 * 58);
      chk("at_0002", 32'(display), 32'h0002);
      wait_n(7);
      chk("no_early_finish", 32'(finish), 32'h0);
      wait_n(1);
      chk("finish_pulse", 32'({display, finish, alarm}), {14'h0, 16'h0000, 2'b11});
      wait_n(1);
      chk("finish_one_cycle", 32'(finish), 32'h0);
      wait_n(10);
      chk("alarm_held", 32'(alarm), 32'h1);
      wait_n(1);
      chk("alarm_drop", 32'(alarm), 32'h0);

      // Pause with the prescaler at 2, blink, then resume.
      drive(1, 0, 0, 0);
      drive(0, 0, 1, 0);
      wait_n(4 * 55);
      chk("at_0005", 32'(display), 32'h0005);
      wait_n(1);
      drive(0, 0, 1, 0);
      chk("pause_run", 32'(running), 32'h0);
      chk("blank_p0", 32'(blank), 32'h0);
      wait_n(1); chk("blank_p1", 32'(blank), 32'h0);
      wait_n(1); chk("blank_p2", 32'(blank), 32'h1);
      wait_n(1); chk("blank_p3", 32'(blank), 32'h1);
      wait_n(1); chk("blank_p4", 32'(blank), 32'h0);
      chk("pause_hold", 32'(display), 32'h0005);
      drive(0, 0, 1, 0);
      chk("resume_run", 32'(running), 32'h1);
      wait_n(1); chk("resume_not_yet", 32'(display), 32'h0005);
      wait_n(1); chk("resume_tick", 32'(display), 32'h0004);
      wait_n(3);
      drive(0, 0, 1, 0);
      chk("tick_then_pause", 32'({display, running}), {15'h0, 16'h0003, 1'b0});
      drive(0, 0, 0, 1);
      chk("pause_clear", 32'(display), 32'h0);

      repeat (99) drive(1, 0, 0, 0);
      chk("at_9900", 32'(display), 32'h9900);
      drive(1, 0, 0, 0);
      chk("sat_max", 32'(display), 32'h9959);
      drive(1, 0, 0, 0);
      chk("sat_hold", 32'(display), 32'h9959);
      drive(0, 1, 0, 0);
      chk("minus_from_max", 32'(display), 32'h9859);
      drive(0, 0, 0, 1);

      drive(1, 0, 0, 0);
      drive(0, 0, 1, 0);
      wait_n(5);
      pulse_reset();
      chk("rst_mid_run", 32'({display, blank, running, finish, alarm}), 32'h0);

      drive(1, 0, 0, 0);
      drive(0, 0, 1, 0);
      wait_n(240);
      chk("done_again", 32'(alarm), 32'h1);
      wait_n(2);
      pulse_reset();
      chk("rst_mid_done", 32'({display, blank, running, finish, alarm}), 32'h0);

      drive(1, 0, 0, 0);
      drive(0, 0, 1, 0);
      wait_n(240);
      chk("done_third", 32'(alarm), 32'h1);
      drive(1, 0, 0, 0);
      chk("done_abort", 32'({display, alarm}), 32'h0);
      drive(1, 0, 0, 0);
      chk("idle_after_abort", 32'(display), 32'h0100);
      drive(0, 0, 0, 1);

      d2_plus = 1; @(negedge clk); d2_plus = 0;
      chk("dec_load", 32'(d2_display), 32'h100);
      d2_start = 1; @(negedge clk); d2_start = 0;
      wait_n(4);
      chk("dec_tick", 32'(d2_display), 32'h099);
      chk("dec_running", 32'(d2_running), 32'h1);

      wait_n(2);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/bcd_countdown.md
Name: bcd_countdown

Overview:
- Parametrised countdown timer core with BCD digits, an optional MM:SS format, pause/resume, a timed alarm window and a blink mask for the display.
- Sits between the debounced button pulses and the display/beeper blocks.
- Drives the `4*DIGITS`-bit BCD display bus and a level alarm that gates the beeper.

Parameters:
- DIGITS, 4: number of BCD digits; must be >= 2.
- TICK_DIV, 1000000: clk cycles per one-second tick; must be even and >= 4.
- MMSS, 1: 1 = digits [1:0] are seconds 00-59 and digits above are minutes; 0 = pure decimal count.
- STEP_DIGIT, 2: digit index adjusted by plus/minus; range 0..DIGITS-1.
- ALARM_SECS, 3: alarm duration in ticks.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- plus  in  1  one-cycle pulse: add one unit at STEP_DIGIT
- minus  in  1  one-cycle pulse: subtract one unit at STEP_DIGIT
- start  in  1  one-cycle pulse: start/pause toggle
- clear  in  1  one-cycle pulse: abort and zero the count
- display  out  4*DIGITS  BCD value, digit 0 in bits [3:0]
- blank  out  1  1 = display should be blanked (blink)
- running  out  1  high while in RUN
- finish  out  1  one-cycle pulse when the count reaches zero
- alarm  out  1  high during the alarm window

Behaviour:
- Reset: rst_n sampled on the rising edge of clk only.
  - While low: value=0, state=IDLE, prescaler=0, blink phase=0.
  - Outputs while low: display=0, blank=0, running=0, finish=0, alarm=0.
- Input priority in one cycle: clear > start > plus > minus. Only the highest-priority pulse takes effect; the rest are dropped.
- All outputs are registered. display reflects the new value in the cycle after the causing pulse or tick.
- Value range:
  - MMSS=1: max is all 9s above digit 1, and 59 in digits [1:0] (4 digits: 99:59). Digit 1 never exceeds 5.
  - MMSS=0: max is all 9s.
- plus: add one unit at STEP_DIGIT, carrying upward (MMSS seconds digit 1 carries at 6). If the result would exceed max, value = max.
- minus: subtract one unit at STEP_DIGIT, borrowing upward. If value < one unit, value = 0.
- States:
  - IDLE: plus/minus adjust the value.
    - start with value != 0: go to RUN, prescaler=0.
    - start with value = 0: ignored.
    - clear: value=0.
  - RUN: running=1. Prescaler counts 0..TICK_DIV-1; on the terminal count it wraps to 0 and value decrements by 1 at digit 0 (MMSS borrow: xx:00 -> (xx-1):59).
    - Decrement to 0: go to DONE; the same cycle loads finish=1 and alarm=1.
    - plus/minus: ignored.
    - start: go to PAUSE, prescaler frozen.
    - clear: go to IDLE, value=0.
  - PAUSE: prescaler held; plus/minus ignored.
    - start: go to RUN, prescaler resumes from its held count (no lost partial second).
    - clear: go to IDLE, value=0.
    - Blink phase toggles every TICK_DIV/2 cycles from PAUSE entry; blank = phase. Phase is 0 on entry, so the first half-period is visible.
  - DONE: value=0, finish high exactly one cycle (first cycle of DONE), alarm high.
    - Prescaler restarts from 0 on DONE entry. After ALARM_SECS ticks: alarm=0, go to IDLE.
    - Any of start/clear/plus/minus: alarm=0, go to IDLE. The pulse is consumed, not applied to the value.
- blank=0 in every state other than PAUSE. Leaving PAUSE clears the blink phase.
- Tick landing on the same cycle as a start in RUN: the tick applies first, then PAUSE is entered. If that tick reaches zero, DONE wins and start is dropped.
- Reset mid-operation: returns to the reset state within one cycle, regardless of state.

Test Plan:
- TICK_DIV=4, MMSS=1, STEP_DIGIT=2: plus x3 -> display=0x0300. start -> running=1. After 4 cycles display=0x0259; after 8 cycles display=0x0258.
- Load 00:02, start -> finish pulses exactly once, 8 cycles after start, with display=0x0000 and alarm=1. alarm drops 12 cycles later (ALARM_SECS=3) and the state returns to IDLE.
- Load 00:05, start, wait 2 cycles, start -> blank toggles every 2 cycles with display held. start again -> the next decrement arrives 2 cycles later (prescaler resumed, not restarted).
- Saturation:
  - plus pulses from 99:00 -> display stays 0x9959.
  - From 00:30, minus -> display=0x0000.
  - start at 0 -> running stays 0.
- Same cycle, plus+minus in IDLE at 01:00 -> 02:00. clear+start in RUN -> IDLE, 0x0000, running=0.
- rst_n=0 for one cycle mid-RUN and mid-DONE -> next cycle all outputs 0, state IDLE. MMSS=0, DIGITS=3: count from 100 -> 099.
